// File: rtl/alu_seq_ctrl_pkg.sv
// Shared constants for the ALU sequencer: micro-op codes, ARM condition
// codes, flag bit positions and the sequencer state encoding.
package alu_seq_pkg;

  localparam int UOP_NOP = 0;
  localparam int UOP_ADD = 1;
  localparam int UOP_SUB = 2;
  localparam int UOP_AND = 3;
  localparam int UOP_XOR = 4;
  localparam int UOP_CMP = 5;
  localparam int UOP_LSL = 6;
  localparam int UOP_LSR = 7;
  localparam int UOP_MOV = 8;
  localparam int UOP_MAX = UOP_MOV;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Flags are packed as [Z,C,N,V]
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // EXEC2 is only reachable when the registered-ALU variant is built
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPS   = 2'd1,
    S_EXEC  = 2'd2,
    S_EXEC2 = 2'd3
  } state_e;

endpackage

// File: rtl/alu_cond_eval.sv
// ARM condition-code evaluator: (cond, flags[Z,C,N,V]) -> pass.
module alu_cond_eval
  import alu_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic z, c, n, v;
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  // Decode the condition against the current flags; NV never passes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Single-issue sequencer around a combinational ALU.
// IDLE -> OPS (operand read + condition check) -> EXEC (drive ALU, write back) -> IDLE.
// Build option ALU_RETIME_EN: inserts EXEC2 after EXEC for a registered-output
// ALU; writeback then happens at the end of EXEC2.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int UOP_W    = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [UOP_W-1:0]            instr_uop,
  input  logic [3:0]                  instr_cond,
  input  logic [$clog2(NUM_REGS)-1:0] instr_rd,
  input  logic [$clog2(NUM_REGS)-1:0] instr_rn,
  input  logic [$clog2(NUM_REGS)-1:0] instr_rm,
  input  logic [DATA_W-1:0]           instr_imm,
  input  logic                        instr_use_imm,
  input  logic                        instr_set_flags,
  output logic [UOP_W-1:0]            alu_uop,
  output logic [DATA_W-1:0]           alu_lhs,
  output logic [DATA_W-1:0]           alu_rhs,
  input  logic [DATA_W-1:0]           alu_out,
  input  logic [3:0]                  alu_flags,
  output logic [3:0]                  flags_q,
  output logic                        done_valid,
  output logic                        done_skipped,
  output logic                        err_uop,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_data
);

  localparam int IDX_W = $clog2(NUM_REGS);

`ifdef ALU_RETIME_EN
  localparam state_e S_WB = S_EXEC2;
`else
  localparam state_e S_WB = S_EXEC;
`endif

  state_e              state_q, state_d;
  logic [UOP_W-1:0]    uop_q, uop_d;
  logic [3:0]          cond_q, cond_d;
  logic [IDX_W-1:0]    rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                use_imm_q, use_imm_d, set_flags_q, set_flags_d;
  logic [DATA_W-1:0]   lhs_q, lhs_d, rhs_q, rhs_d;
  logic [3:0]          flags_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                done_valid_q, done_valid_d;
  logic                done_skipped_q, done_skipped_d;
  logic                err_uop_q, err_uop_d;
  logic                cond_pass, uop_legal, writes_rd, in_exec;

  alu_cond_eval u_cond (
    .cond  (cond_q),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  assign uop_legal = (uop_q <= UOP_W'(UOP_MAX));
  assign writes_rd = (uop_q != UOP_W'(UOP_NOP)) && (uop_q != UOP_W'(UOP_CMP));

`ifdef ALU_RETIME_EN
  assign in_exec = (state_q == S_EXEC) || (state_q == S_EXEC2);
`else
  assign in_exec = (state_q == S_EXEC);
`endif

  assign instr_ready  = (state_q == S_IDLE);
  assign alu_uop      = in_exec ? uop_q : UOP_W'(UOP_NOP);
  assign alu_lhs      = lhs_q;
  assign alu_rhs      = rhs_q;
  assign done_valid   = done_valid_q;
  assign done_skipped = done_skipped_q;
  assign err_uop      = err_uop_q;
  assign dbg_data     = regs_q[dbg_addr];

  // Next-state, field capture, operand fetch and writeback
  always_comb begin
    state_d        = state_q;
    uop_d          = uop_q;
    cond_d         = cond_q;
    rd_d           = rd_q;
    rn_d           = rn_q;
    rm_d           = rm_q;
    imm_d          = imm_q;
    use_imm_d      = use_imm_q;
    set_flags_d    = set_flags_q;
    lhs_d          = lhs_q;
    rhs_d          = rhs_q;
    flags_d        = flags_q;
    regs_d         = regs_q;
    done_valid_d   = 1'b0;
    done_skipped_d = 1'b0;
    err_uop_d      = 1'b0;
    case (state_q)
      S_IDLE: if (instr_valid) begin
        uop_d       = instr_uop;
        cond_d      = instr_cond;
        rd_d        = instr_rd;
        rn_d        = instr_rn;
        rm_d        = instr_rm;
        imm_d       = instr_imm;
        use_imm_d   = instr_use_imm;
        set_flags_d = instr_set_flags;
        state_d     = S_OPS;
      end
      S_OPS: begin
        if (!cond_pass) begin
          state_d        = S_IDLE;
          done_valid_d   = 1'b1;
          done_skipped_d = 1'b1;
        end else if (!uop_legal) begin
          state_d      = S_IDLE;
          done_valid_d = 1'b1;
          err_uop_d    = 1'b1;
        end else begin
          // Operands only move when the ALU will actually be used
          lhs_d   = regs_q[rn_q];
          rhs_d   = use_imm_q ? imm_q : regs_q[rm_q];
          state_d = S_EXEC;
        end
      end
`ifdef ALU_RETIME_EN
      S_EXEC:  state_d = S_EXEC2;
`else
      S_EXEC:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
    // Retire: result and flags are sampled on the last ALU cycle
    if (state_q == S_WB) begin
      state_d      = S_IDLE;
      done_valid_d = 1'b1;
      if (writes_rd) regs_d[rd_q] = alu_out;
      if (set_flags_q || (uop_q == UOP_W'(UOP_CMP))) flags_d = alu_flags;
    end
  end

  // State and datapath registers; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      uop_q          <= '0;
      cond_q         <= '0;
      rd_q           <= '0;
      rn_q           <= '0;
      rm_q           <= '0;
      imm_q          <= '0;
      use_imm_q      <= 1'b0;
      set_flags_q    <= 1'b0;
      lhs_q          <= '0;
      rhs_q          <= '0;
      flags_q        <= '0;
      done_valid_q   <= 1'b0;
      done_skipped_q <= 1'b0;
      err_uop_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      uop_q          <= uop_d;
      cond_q         <= cond_d;
      rd_q           <= rd_d;
      rn_q           <= rn_d;
      rm_q           <= rm_d;
      imm_q          <= imm_d;
      use_imm_q      <= use_imm_d;
      set_flags_q    <= set_flags_d;
      lhs_q          <= lhs_d;
      rhs_q          <= rhs_d;
      flags_q        <= flags_d;
      done_valid_q   <= done_valid_d;
      done_skipped_q <= done_skipped_d;
      err_uop_q      <= err_uop_d;
      regs_q         <= regs_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural combinational ALU.
module tb_alu_seq_ctrl;

`ifdef ALU_RETIME_EN
  localparam int EXEC_LAT = 4;
`else
  localparam int EXEC_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [4:0]  instr_uop = '0;
  logic [3:0]  instr_cond = '0;
  logic [3:0]  instr_rd = '0, instr_rn = '0, instr_rm = '0;
  logic [31:0] instr_imm = '0;
  logic        instr_use_imm = 1'b0, instr_set_flags = 1'b0;
  logic [4:0]  alu_uop;
  logic [31:0] alu_lhs, alu_rhs, alu_out;
  logic [3:0]  alu_flags, flags_q;
  logic        done_valid, done_skipped, err_uop;
  logic [3:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_uop(instr_uop), .instr_cond(instr_cond),
    .instr_rd(instr_rd), .instr_rn(instr_rn), .instr_rm(instr_rm),
    .instr_imm(instr_imm), .instr_use_imm(instr_use_imm), .instr_set_flags(instr_set_flags),
    .alu_uop(alu_uop), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
    .alu_out(alu_out), .alu_flags(alu_flags), .flags_q(flags_q),
    .done_valid(done_valid), .done_skipped(done_skipped), .err_uop(err_uop),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU: flags [Z,C,N,V], ARM carry (no-borrow) for SUB/CMP
  logic [32:0] m_sum;
  logic        m_c, m_v;
  always_comb begin
    m_sum   = '0;
    alu_out = '0;
    m_c     = 1'b0;
    m_v     = 1'b0;
    case (alu_uop)
      5'd1: begin
        m_sum = {1'b0, alu_lhs} + {1'b0, alu_rhs};
        alu_out = m_sum[31:0]; m_c = m_sum[32];
        m_v = (alu_lhs[31] == alu_rhs[31]) && (alu_out[31] != alu_lhs[31]);
      end
      5'd2, 5'd5: begin
        m_sum = {1'b0, alu_lhs} + {1'b0, ~alu_rhs} + 33'd1;
        alu_out = m_sum[31:0]; m_c = m_sum[32];
        m_v = (alu_lhs[31] != alu_rhs[31]) && (alu_out[31] != alu_lhs[31]);
      end
      5'd3: alu_out = alu_lhs & alu_rhs;
      5'd4: alu_out = alu_lhs ^ alu_rhs;
      5'd6: alu_out = alu_lhs << alu_rhs[4:0];
      5'd7: alu_out = alu_lhs >> alu_rhs[4:0];
      5'd8: alu_out = alu_rhs;
      default: alu_out = '0;
    endcase
  end
  assign alu_flags = {(alu_out == 32'd0), m_c, alu_out[31], m_v};

  // Offer one instruction and return just after the accepting edge
  task automatic issue(input logic [4:0] uop, input logic [3:0] cond, input logic [3:0] rd,
                       input logic [3:0] rn, input logic [3:0] rm, input logic [31:0] imm,
                       input logic ui, input logic sf);
    int t;
    instr_uop = uop; instr_cond = cond; instr_rd = rd; instr_rn = rn; instr_rm = rm;
    instr_imm = imm; instr_use_imm = ui; instr_set_flags = sf; instr_valid = 1'b1;
    t = 0;
    while (!instr_ready && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // Latency in edges from the accept edge to the edge that samples done_valid; -1 on timeout
  task automatic wait_done(output int lat, output logic skp, output logic err);
    lat = -1; skp = 1'b0; err = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done_valid) begin lat = k; skp = done_skipped; err = err_uop; break; end
    end
  endtask

  task automatic rd_reg(input logic [3:0] idx, output logic [31:0] d);
    dbg_addr = idx; #1; d = dbg_data;
  endtask

  task automatic test_reset();
    int lat; logic skp, err; logic [31:0] d; int nz;
    issue(5'd8, 4'd14, 4'd9, 4'd0, 4'd0, 32'd5, 1'b1, 1'b1);
    wait_done(lat, skp, err);
    rd_reg(4'd9, d);
    n_cmp++; if (d !== 32'd5) begin n_bad++; $display("FAIL pre_reset_r9: got %h want %h", d, 32'd5); end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    n_cmp++; if (flags_q !== 4'h0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", flags_q); end
    n_cmp++; if (alu_uop !== 5'd0) begin n_bad++; $display("FAIL reset_alu_uop: got %h want 0", alu_uop); end
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    n_cmp++; if ({alu_lhs, alu_rhs} !== 64'd0) begin n_bad++; $display("FAIL reset_operands: got %h/%h want 0", alu_lhs, alu_rhs); end
    n_cmp++; if ({done_valid, done_skipped, err_uop} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {done_valid, done_skipped, err_uop}); end
    nz = 0;
    for (int i = 0; i < 16; i++) begin rd_reg(4'(i), d); if (d !== 32'd0) nz++; end
    n_cmp++; if (nz != 0) begin n_bad++; $display("FAIL reset_regfile: got %0d nonzero regs want 0", nz); end
  endtask

  task automatic test_mov();
    logic [4:0] u [1:EXEC_LAT]; logic dv [1:EXEC_LAT]; logic [31:0] d; logic [4:0] want_u;
    @(negedge clk);
    issue(5'd8, 4'd14, 4'd1, 4'd0, 4'd0, 32'h12345678, 1'b1, 1'b0);
    for (int k = 1; k <= EXEC_LAT; k++) begin @(negedge clk); u[k] = alu_uop; dv[k] = done_valid; end
    for (int k = 1; k <= EXEC_LAT; k++) begin
      want_u = (k >= 2 && k < EXEC_LAT) ? 5'd8 : 5'd0;
      n_cmp++; if (u[k] !== want_u) begin n_bad++; $display("FAIL mov_alu_uop_k%0d: got %0d want %0d", k, u[k], want_u); end
      n_cmp++; if (dv[k] !== (k == EXEC_LAT)) begin n_bad++; $display("FAIL mov_done_k%0d: got %b want %b", k, dv[k], k == EXEC_LAT); end
    end
    rd_reg(4'd1, d);
    n_cmp++; if (d !== 32'h12345678) begin n_bad++; $display("FAIL mov_r1: got %h want 12345678", d); end
    n_cmp++; if (flags_q !== 4'h0) begin n_bad++; $display("FAIL mov_flags: got %h want 0", flags_q); end
  endtask

  task automatic test_cond();
    int lat; logic skp, err; logic [31:0] d;
    issue(5'd2, 4'd14, 4'd2, 4'd1, 4'd1, 32'd0, 1'b0, 1'b1);
    wait_done(lat, skp, err);
    n_cmp++; if (lat != EXEC_LAT) begin n_bad++; $display("FAIL sub_latency: got %0d want %0d", lat, EXEC_LAT); end
    rd_reg(4'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL sub_r2: got %h want 0", d); end
    n_cmp++; if (flags_q !== 4'b1100) begin n_bad++; $display("FAIL sub_flags: got %b want 1100", flags_q); end
    issue(5'd1, 4'd1, 4'd3, 4'd1, 4'd0, 32'd1, 1'b1, 1'b0);
    wait_done(lat, skp, err);
    n_cmp++; if (lat != 2 || skp !== 1'b1) begin n_bad++; $display("FAIL addne_skip: got lat %0d skp %b want lat 2 skp 1", lat, skp); end
    rd_reg(4'd3, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL addne_r3: got %h want 0", d); end
    issue(5'd1, 4'd0, 4'd3, 4'd1, 4'd0, 32'd1, 1'b1, 1'b0);
    wait_done(lat, skp, err);
    n_cmp++; if (lat != EXEC_LAT || skp !== 1'b0) begin n_bad++; $display("FAIL addeq_exec: got lat %0d skp %b want lat %0d skp 0", lat, skp, EXEC_LAT); end
    rd_reg(4'd3, d);
    n_cmp++; if (d !== 32'h12345679) begin n_bad++; $display("FAIL addeq_r3: got %h want 12345679", d); end
  endtask

  task automatic test_cmp();
    int lat; logic skp, err; logic [31:0] d;
    issue(5'd8, 4'd14, 4'd4, 4'd0, 4'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
    wait_done(lat, skp, err);
    issue(5'd8, 4'd14, 4'd5, 4'd0, 4'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
    wait_done(lat, skp, err);
    issue(5'd5, 4'd14, 4'd7, 4'd4, 4'd5, 32'd0, 1'b0, 1'b0);
    wait_done(lat, skp, err);
    n_cmp++; if (flags_q !== 4'b0011) begin n_bad++; $display("FAIL cmp_flags: got %b want 0011", flags_q); end
    rd_reg(4'd7, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL cmp_r7: got %h want 0", d); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, lat; logic skp, err; logic [31:0] d;
    instr_uop = 5'd1; instr_cond = 4'd14; instr_rd = 4'd5; instr_rn = 4'd1; instr_rm = 4'd0;
    instr_imm = 32'd1; instr_use_imm = 1'b1; instr_set_flags = 1'b0; instr_valid = 1'b1;
    a0 = -1;
    for (int t = 0; t < 20; t++) begin @(negedge clk); if (instr_ready) begin a0 = cyc + 1; break; end end
    @(posedge clk); #1;
    instr_uop = 5'd6; instr_rd = 4'd6; instr_rn = 4'd5;
    a1 = -1;
    for (int t = 0; t < 20; t++) begin @(negedge clk); if (instr_ready) begin a1 = cyc + 1; break; end end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wait_done(lat, skp, err);
    n_cmp++; if (a0 < 0 || a1 - a0 != EXEC_LAT) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", a1 - a0, EXEC_LAT); end
    n_cmp++; if (lat != EXEC_LAT) begin n_bad++; $display("FAIL b2b_lsl_latency: got %0d want %0d", lat, EXEC_LAT); end
    rd_reg(4'd6, d);
    n_cmp++; if (d !== 32'h2468ACF2) begin n_bad++; $display("FAIL b2b_r6: got %h want 2468acf2", d); end
    issue(5'h1F, 4'd14, 4'd9, 4'd1, 4'd0, 32'd1, 1'b1, 1'b1);
    wait_done(lat, skp, err);
    n_cmp++; if (lat != 2 || err !== 1'b1 || skp !== 1'b0) begin n_bad++; $display("FAIL illegal_uop: got lat %0d err %b skp %b want lat 2 err 1 skp 0", lat, err, skp); end
    rd_reg(4'd9, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL illegal_r9: got %h want 0", d); end
    n_cmp++; if (flags_q !== 4'b0011) begin n_bad++; $display("FAIL illegal_flags: got %b want 0011", flags_q); end
  endtask

  task automatic test_abort();
    logic seen; logic [31:0] d;
    issue(5'd8, 4'd14, 4'd8, 4'd0, 4'd0, 32'hDEADBEEF, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if (alu_uop !== 5'd8) begin n_bad++; $display("FAIL abort_in_exec: got %0d want 8", alu_uop); end
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= done_valid; end
    #2 rst_n = 1'b1;
    repeat (4) begin @(negedge clk); seen |= done_valid; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", seen); end
    rd_reg(4'd8, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL abort_r8: got %h want 0", d); end
    n_cmp++; if (instr_ready !== 1'b1 || alu_uop !== 5'd0) begin n_bad++; $display("FAIL abort_idle: got ready %b uop %0d want 1/0", instr_ready, alu_uop); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_mov();
    test_cond();
    test_cmp();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Single-issue sequencer wrapped around the combinational ALU (uop/lhs/rhs in; out_alu and flags [Z,C,N,V] out).
- Accepts one data-processing micro-instruction at a time over a valid/ready handshake.
- Reads operands from an internal register file and evaluates an ARM-style condition code against the stored flags.
- Drives the ALU for one cycle, then writes back the result and/or flags.
- Sits between the decode stage and the ALU.

Parameters:
DATA_W, 32, datapath width
NUM_REGS, 16, register file depth (index width = clog2(NUM_REGS))
UOP_W, 5, ALU micro-op width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept
instr_uop  in  UOP_W  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 XOR, 5 CMP, 6 LSL, 7 LSR, 8 MOV
instr_cond  in  4  ARM condition (0 EQ … 14 AL, 15 NV)
instr_rd, instr_rn, instr_rm  in  4 each  register indices
instr_imm  in  DATA_W  immediate for rhs
instr_use_imm  in  1  rhs = imm instead of R[rm]
instr_set_flags  in  1  S bit
alu_uop  out  UOP_W  to ALU
alu_lhs, alu_rhs  out  DATA_W each  to ALU
alu_out  in  DATA_W  from ALU
alu_flags  in  4  from ALU, [Z,C,N,V]
flags_q  out  4  architectural flags [Z,C,N,V]
done_valid  out  1  one-cycle retire pulse
done_skipped  out  1  qualifies done_valid: condition failed
err_uop  out  1  one-cycle pulse on illegal uop
dbg_addr  in  4  register-file debug read index
dbg_data  out  DATA_W  combinational R[dbg_addr]

Behaviour:
Reset (async, rst_n=0):
- State goes to IDLE. All regs, flags_q, alu_lhs and alu_rhs are 0. alu_uop=0.
- done_valid, done_skipped and err_uop are 0. instr_ready=1 once rst_n=1.

FSM IDLE -> OPS -> EXEC -> IDLE:
- IDLE: instr_ready=1. On instr_valid&instr_ready, latch all instr_* fields and go to OPS.
- OPS: instr_ready=0.
  - Register lhs=R[rn] and rhs=(use_imm ? imm : R[rm]).
  - Evaluate cond against flags_q.
    - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
    - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
    - AL 1; NV 0.
  - Cond false -> return to IDLE. Assert done_valid=1 and done_skipped=1 in the next cycle. No ALU activity, no writes.
  - uop>8 -> return to IDLE. Assert done_valid=1 and err_uop=1 next cycle. No writes.
  - Otherwise go to EXEC.
- EXEC: alu_uop=latched uop. At the end of the cycle:
  - R[rd] <= alu_out if uop in {ADD,SUB,AND,XOR,LSL,LSR,MOV}. Never for CMP or NOP.
  - flags_q <= alu_flags if set_flags=1 or uop=CMP.
  - Go to IDLE with done_valid=1 in the following cycle.
- alu_uop=0 (NOP) in every state except EXEC. alu_lhs and alu_rhs hold their last values.
- Latency: accept edge to done_valid is 3 cycles executed, 2 cycles skipped or illegal.
- done_valid coincides with instr_ready=1, so back-to-back issue is 1 instruction per 3 cycles.
- RAW hazards: none. Writeback completes before the next OPS read, so no forwarding is needed.
- rd=rn=rm is legal.
- instr_* fields are ignored while instr_ready=0.
- Reset mid-operation aborts: no write, no done pulse.

Optional Feature:
ALU_RETIME_EN
- Defined: supports a registered-output ALU. Adds state EXEC2 after EXEC. alu_uop is held in both states. Writeback and flags are sampled at the end of EXEC2. Executed latency becomes 4 cycles; skip latency is unchanged.
- Undefined: 3-cycle path as above.

Decomposition:
Package alu_seq_pkg:
- UOP_* constants (NOP..MOV)
- COND_* codes
- flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0
- state enum

Sub-module alu_cond_eval: combinational (cond, flags) -> pass. The register file stays inline.

Test Plan:
1. Reset: hold rst_n=0 mid-run, release -> flags_q=0, dbg_data=0 for all addresses, alu_uop=0, instr_ready=1.
2. MOV r1,#0x12345678 AL S=0 -> alu_uop=8 during EXEC only; done_valid 3 cycles after accept; R1=0x12345678; flags_q unchanged.
3. SUB r2,r1,r1 S=1 -> R2=0, flags_q[Z]=1. Then ADDNE r3,r1,#1 -> done_skipped=1 two cycles after accept, R3 stays 0. Then ADDEQ r3,r1,#1 -> R3=0x12345679.
4. R4=0x7FFFFFFF, R5=0xFFFFFFFF; CMP r7,r4,r5 S=0 -> flags_q = alu_flags of the ALU, R7 unchanged (0).
5. instr_valid held high: ADD r5,r1,#1 then LSL r6,r5,#1 -> accepts every 3 cycles, R6=0x2468ACF2 (no hazard). Then uop=0x1F -> err_uop pulse, no writes.
6. Drop rst_n during EXEC of MOV r8,#0xDEADBEEF -> R8=0, no done_valid, IDLE after release.
